// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by decode-side blocks: field positions, opcode classes,
// decode-stage state encoding and small field-extraction helpers.
package cpu_isa_pkg;

   localparam int ISA_DATA_W = 16;
   localparam int ISA_REG_AW = 3;
   localparam int NUM_REGS   = 1 << ISA_REG_AW;

   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 9;
   localparam int RS_HI    = 8;
   localparam int RS_LO    = 6;
   localparam int RT_HI    = 5;
   localparam int RT_LO    = 3;
   localparam int IMM6_HI  = 5;
   localparam int IMM12_HI = 11;

   typedef logic [3:0]            opcode_t;
   typedef logic [ISA_REG_AW-1:0] reg_addr_t;
   typedef logic [ISA_DATA_W-1:0] word_t;

   localparam opcode_t OP_RTYPE       = 4'd0;
   localparam opcode_t OP_LAST_WRITER = 4'd8;
   localparam opcode_t OP_SW          = 4'd9;
   localparam opcode_t OP_BEQ         = 4'd10;
   localparam opcode_t OP_BNE         = 4'd11;
   localparam opcode_t OP_J_FIRST     = 4'd12;
   localparam opcode_t OP_J_LAST      = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_ISSUE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC2_NONE = 2'd0,
      SRC2_RT   = 2'd1,
      SRC2_RD   = 2'd2
   } src2_e;

   function automatic logic writes_rd(opcode_t opc);
      return opc <= OP_LAST_WRITER;
   endfunction

   function automatic logic reads_rs(opcode_t opc);
      return opc < OP_J_FIRST;
   endfunction

   // Stores and branches carry their second operand in the rd field.
   function automatic src2_e port2_src(opcode_t opc);
      if (opc == OP_RTYPE) return SRC2_RT;
      if (opc == OP_SW || opc == OP_BEQ || opc == OP_BNE) return SRC2_RD;
      return SRC2_NONE;
   endfunction

   function automatic word_t extend_imm(word_t w);
      opcode_t opc = w[OPC_HI:OPC_LO];
      if (opc == OP_RTYPE) return '0;
      if (opc >= OP_J_FIRST) return {{(ISA_DATA_W-IMM12_HI-1){1'b0}}, w[IMM12_HI:0]};
      return {{(ISA_DATA_W-IMM6_HI-1){w[IMM6_HI]}}, w[IMM6_HI:0]};
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for RAW hazard detection; r0 is never busy.
module reg_scoreboard
   import cpu_isa_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  set_en_i,
   input  logic [ISA_REG_AW-1:0] set_reg_i,
   input  logic                  clr_en_i,
   input  logic [ISA_REG_AW-1:0] clr_reg_i,
   input  logic [ISA_REG_AW-1:0] q1_reg_i,
   input  logic [ISA_REG_AW-1:0] q2_reg_i,
   output logic                  q1_busy_o,
   output logic                  q2_busy_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
         assign busy_d[gi] = 1'b0;
      end else begin : g_reg
         // A set on the same edge as a clear of this register must win.
         assign busy_d[gi] = (set_en_i && set_reg_i == reg_addr_t'(gi)) ||
                             (busy_q[gi] && !(clr_en_i && clr_reg_i == reg_addr_t'(gi)));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign q1_busy_o = (q1_reg_i != '0) && busy_q[q1_reg_i];
   assign q2_busy_o = (q2_reg_i != '0) && busy_q[q2_reg_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: holds one instruction, reads its sources once no RAW
// hazard is pending, and offers the decoded bundle to execute over valid/ready.
module operand_fetch_stage
   import cpu_isa_pkg::*;
#(
   parameter int DATA_W = ISA_DATA_W,
   parameter int REG_AW = ISA_REG_AW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              instr_ready,
   output logic [REG_AW-1:0] readReg1,
   output logic [REG_AW-1:0] readReg2,
   input  logic [DATA_W-1:0] readData1,
   input  logic [DATA_W-1:0] readData2,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [3:0]        op_opcode,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] op_imm,
   output logic [REG_AW-1:0] op_dest,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_reg
);

   state_e    state_q, state_d;
   word_t     ir_q;
   word_t     op_a_q, op_b_q, op_imm_q;
   opcode_t   op_opcode_q;
   reg_addr_t op_dest_q;

   opcode_t   ir_opc;
   reg_addr_t src1, src2, dest;
   logic      ir_load, capture, hazard, q1_busy, q2_busy;

   assign ir_opc = ir_q[OPC_HI:OPC_LO];

   // Read addresses always follow IR, so they keep the last instruction while idle.
   always_comb begin
      src1 = reads_rs(ir_opc) ? ir_q[RS_HI:RS_LO] : '0;
      dest = writes_rd(ir_opc) ? ir_q[RD_HI:RD_LO] : '0;
      case (port2_src(ir_opc))
         SRC2_RT: src2 = ir_q[RT_HI:RT_LO];
         SRC2_RD: src2 = ir_q[RD_HI:RD_LO];
         default: src2 = '0;
      endcase
   end

   assign readReg1 = src1;
   assign readReg2 = src2;

   reg_scoreboard u_scoreboard (
      .clock     (clock),
      .reset     (reset),
      .set_en_i  (capture && dest != '0),
      .set_reg_i (dest),
      .clr_en_i  (wb_valid),
      .clr_reg_i (wb_reg),
      .q1_reg_i  (src1),
      .q2_reg_i  (src2),
      .q1_busy_o (q1_busy),
      .q2_busy_o (q2_busy)
   );

   assign hazard = q1_busy || q2_busy;

   always_comb begin
      state_d = state_q;
      ir_load = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               ir_load = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!hazard) begin
               capture = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (op_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_imm_q    <= '0;
         op_opcode_q <= '0;
         op_dest_q   <= '0;
      end else begin
         state_q <= state_d;
         if (ir_load) ir_q <= instr;
         if (capture) begin
            op_a_q      <= readData1;
            op_b_q      <= readData2;
            op_imm_q    <= extend_imm(ir_q);
            op_opcode_q <= ir_opc;
            op_dest_q   <= dest;
         end
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign op_valid    = (state_q == ST_ISSUE);
   assign op_opcode   = op_opcode_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_imm      = op_imm_q;
   assign op_dest     = op_dest_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_operand_fetch_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'd0;
   logic        instr_ready;
   logic [2:0]  readReg1, readReg2;
   logic [15:0] readData1, readData2;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [3:0]  op_opcode;
   logic [15:0] op_a, op_b, op_imm;
   logic [2:0]  op_dest;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_reg = 3'd0;

   logic [15:0] regs [8];
   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   // Register file r0 reads as zero
   assign readData1 = (readReg1 == 3'd0) ? 16'd0 : regs[readReg1];
   assign readData2 = (readReg2 == 3'd0) ? 16'd0 : regs[readReg2];

   operand_fetch_stage dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .readReg1    (readReg1),
      .readReg2    (readReg2),
      .readData1   (readData1),
      .readData2   (readData2),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_opcode   (op_opcode),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_imm      (op_imm),
      .op_dest     (op_dest),
      .wb_valid    (wb_valid),
      .wb_reg      (wb_reg)
   );

   // ---------------- reference rules ----------------
   function automatic logic [2:0] f_src1(logic [15:0] w);
      int op = int'(w[15:12]);
      return (op <= 11) ? w[8:6] : 3'd0;
   endfunction

   function automatic logic [2:0] f_src2(logic [15:0] w);
      int op = int'(w[15:12]);
      if (op == 0) return w[5:3];
      if (op >= 9 && op <= 11) return w[11:9];
      return 3'd0;
   endfunction

   function automatic logic [2:0] f_dest(logic [15:0] w);
      int op = int'(w[15:12]);
      return (op <= 8) ? w[11:9] : 3'd0;
   endfunction

   function automatic logic [15:0] f_imm(logic [15:0] w);
      int op = int'(w[15:12]);
      int v;
      if (op == 0) return 16'd0;
      if (op >= 12) return {4'd0, w[11:0]};
      v = int'(w[5:0]);
      if (v >= 32) v = v - 64;
      return 16'(v);
   endfunction

   // ---------------- behavioural model ----------------
   // m_phase: 0 = free for a new instruction, 1 = holding one awaiting operands,
   // 2 = decoded bundle on offer to execute.
   int          m_phase = 0;
   logic [15:0] m_ir = 16'd0, m_a = 16'd0, m_b = 16'd0, m_imm = 16'd0;
   logic [3:0]  m_opc = 4'd0;
   logic [2:0]  m_dest = 3'd0, m_s1, m_s2;
   logic [7:0]  m_busy = 8'd0, m_nb;
   logic        m_hz;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_phase = 0;
         m_ir = 16'd0; m_a = 16'd0; m_b = 16'd0; m_imm = 16'd0;
         m_opc = 4'd0; m_dest = 3'd0; m_busy = 8'd0;
      end else begin
         m_s1 = f_src1(m_ir);
         m_s2 = f_src2(m_ir);
         m_hz = (m_s1 != 0 && m_busy[m_s1]) || (m_s2 != 0 && m_busy[m_s2]);
         m_nb = m_busy;
         if (wb_valid && wb_reg != 0) m_nb[wb_reg] = 1'b0;
         if (m_phase == 0) begin
            if (instr_valid) begin
               m_ir = instr;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (!m_hz) begin
               m_a    = (m_s1 == 0) ? 16'd0 : regs[m_s1];
               m_b    = (m_s2 == 0) ? 16'd0 : regs[m_s2];
               m_imm  = f_imm(m_ir);
               m_opc  = m_ir[15:12];
               m_dest = f_dest(m_ir);
               if (m_dest != 0) m_nb[m_dest] = 1'b1;
               m_phase = 2;
            end
         end else if (op_ready) begin
            m_phase = 0;
         end
         m_busy = m_nb;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clock) begin
      chk("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
      chk("op_valid",    32'(op_valid),    32'(m_phase == 2));
      chk("readReg1",    32'(readReg1),    32'(f_src1(m_ir)));
      chk("readReg2",    32'(readReg2),    32'(f_src2(m_ir)));
      chk("op_opcode",   32'(op_opcode),   32'(m_opc));
      chk("op_a",        32'(op_a),        32'(m_a));
      chk("op_b",        32'(op_b),        32'(m_b));
      chk("op_imm",      32'(op_imm),      32'(m_imm));
      chk("op_dest",     32'(op_dest),     32'(m_dest));
      chk("busy",        32'(dut.u_scoreboard.busy_q), 32'(m_busy));
      if (op_valid && op_ready && !reset)
         $display("[TB] issue opcode=%0d a=%h b=%h imm=%h dest=%0d",
                  op_opcode, op_a, op_b, op_imm, op_dest);
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic present(input logic [15:0] w);
      instr = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = 16'd0;
      #1 reset = 1'b1;
      step();
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_op_valid",    32'(op_valid),    32'd0);
      chk("rst_readReg1",    32'(readReg1),    32'd0);
      chk("rst_busy",        32'(dut.u_scoreboard.busy_q), 32'd0);
      #2 reset = 1'b0;
      step();

      // R-type 0x0A98: rd=5 rs=2 rt=3
      regs[2] = 16'd256;
      regs[3] = 16'd7;
      present(16'h0A98);
      chk("r_readReg1",  32'(readReg1), 32'd2);
      chk("r_readReg2",  32'(readReg2), 32'd3);
      chk("r_dec_valid", 32'(op_valid), 32'd0);
      step();
      chk("r_op_valid",  32'(op_valid),  32'd1);
      chk("r_op_a",      32'(op_a),      32'd256);
      chk("r_op_b",      32'(op_b),      32'd7);
      chk("r_op_dest",   32'(op_dest),   32'd5);
      chk("r_op_opcode", 32'(op_opcode), 32'd0);
      chk("r_busy5",     32'(dut.u_scoreboard.busy_q[5]), 32'd1);
      // Hold in ISSUE with a competing instruction offered
      instr = 16'hFFFF;
      instr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("hold_valid", 32'(op_valid),    32'd1);
         chk("hold_ready", 32'(instr_ready), 32'd0);
         chk("hold_a",     32'(op_a),        32'd256);
         chk("hold_dest",  32'(op_dest),     32'd5);
      end
      instr_valid = 1'b0;
      op_ready = 1'b1;
      step();
      chk("rel_instr_ready", 32'(instr_ready), 32'd1);
      chk("rel_op_valid",    32'(op_valid),    32'd0);

      // I-type with negative imm6
      present(16'h1FBF);
      step();
      chk("i_op_imm",  32'(op_imm),  32'hFFFF);
      chk("i_op_dest", 32'(op_dest), 32'd7);
      step();
      wb_valid = 1'b1; wb_reg = 3'd7;
      step();
      wb_valid = 1'b0;
      chk("i_busy_after_wb", 32'(dut.u_scoreboard.busy_q), 32'h20);

      // J-type
      present(16'hC123);
      chk("j_readReg1", 32'(readReg1), 32'd0);
      chk("j_readReg2", 32'(readReg2), 32'd0);
      step();
      chk("j_op_imm",  32'(op_imm),  32'h0123);
      chk("j_op_dest", 32'(op_dest), 32'd0);
      chk("j_busy",    32'(dut.u_scoreboard.busy_q), 32'h20);
      step();

      // RAW stall on r5: 0x0340 = R-type rd=1 rs=5 rt=0
      regs[5] = 16'h1234;
      present(16'h0340);
      chk("raw_readReg1", 32'(readReg1), 32'd5);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("raw_stall", 32'(op_valid), 32'd0);
      end
      regs[5] = 16'hBEEF;
      wb_valid = 1'b1; wb_reg = 3'd5;
      step();
      wb_valid = 1'b0;
      chk("raw_wb_edge_stall", 32'(op_valid), 32'd0);
      step();
      chk("raw_resolved", 32'(op_valid), 32'd1);
      chk("raw_op_a",     32'(op_a),     32'hBEEF);
      chk("raw_busy",     32'(dut.u_scoreboard.busy_q), 32'h02);
      step();

      // Same-edge set and clear of r5
      present(16'h0A98);
      wb_valid = 1'b1; wb_reg = 3'd5;
      step();
      wb_valid = 1'b0;
      chk("setclr_busy", 32'(dut.u_scoreboard.busy_q), 32'h22);
      step();

      // Asynchronous reset while stalled in DECODE
      present(16'h0340);
      #1 reset = 1'b1;
      #1;
      chk("areset_op_valid",    32'(op_valid),    32'd0);
      chk("areset_instr_ready", 32'(instr_ready), 32'd1);
      chk("areset_busy",        32'(dut.u_scoreboard.busy_q), 32'd0);
      chk("areset_readReg1",    32'(readReg1),    32'd0);
      #1 reset = 1'b0;
      step();
      present(16'h0A98);
      step();
      chk("post_reset_valid", 32'(op_valid), 32'd1);
      chk("post_reset_a",     32'(op_a),     32'd256);
      step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         instr_valid = 1'($urandom_range(0, 1));
         instr       = 16'($urandom);
         op_ready    = ($urandom_range(0, 3) != 0);
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_reg      = 3'($urandom_range(0, 7));
         regs[$urandom_range(1, 7)] = 16'($urandom);
         reset       = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0;
      instr_valid = 1'b0;
      wb_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
